// File: rtl/i2c_passthru_pkg.sv
// i2c_passthru_pkg: bit-level FSM encodings shared by the passthru receiver and transmitter.
package i2c_passthru_pkg;
    typedef enum logic [2:0] {FREE, IDLE, SETUP, REL, HIGH, VIOLATION} state_t;
endpackage

// File: rtl/i2c_passthru_bitrx_if.sv
// i2c_passthru_bitrx_if: driving-side bus, downstream request and resolved-bit outputs.
interface i2c_passthru_bitrx_if;
    logic i_f_ref;
    logic i_start_rx;
    logic i_scl;
    logic i_sda;
    logic o_scl;
    logic o_sda_init_valid;
    logic o_sda_init;
    logic o_sda_mid_change;
    logic o_sda_final;
    logic o_done;
    logic o_bus_free;
    logic o_violation;
    modport master (
        output i_f_ref, i_start_rx, i_scl, i_sda,
        input  o_scl, o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final,
               o_done, o_bus_free, o_violation
    );
    modport slave (
        input  i_f_ref, i_start_rx, i_scl, i_sda,
        output o_scl, o_sda_init_valid, o_sda_init, o_sda_mid_change, o_sda_final,
               o_done, o_bus_free, o_violation
    );
endinterface

// File: rtl/i2c_passthru_ref_timer.sv
// i2c_passthru_ref_timer: f_ref rising-edge driven down-counter, reloadable, tc at zero.
module i2c_passthru_ref_timer #(
    parameter int LOAD  = 2,
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic f_ref,
    input  logic load,
    output logic tc
);
    logic             f_ref_q;
    logic [WIDTH-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_ref_q <= 1'b0;
            cnt     <= WIDTH'(LOAD);
        end else begin
            f_ref_q <= f_ref;
            cnt     <= load ? WIDTH'(LOAD) :
                       (f_ref && !f_ref_q && cnt != '0) ? cnt - 1'b1 : cnt;
        end
    end
    assign tc = cnt == '0;
endmodule

// File: rtl/i2c_passthru_bitrx.sv
// i2c_passthru_bitrx: resolves one driving-side bit period into init/mid/final values,
// stretching SCL low between bits until downstream asks for the next one.
module i2c_passthru_bitrx
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_T_SU_DAT       = 2,
    parameter int F_REF_T_LOW          = 38,
    parameter int WIDTH_F_REF_T_SU_DAT = 2,
    parameter int WIDTH_F_REF_T_LOW    = 6
) (
    input logic i_clk,
    input logic i_rst,
    i2c_passthru_bitrx_if.slave bus
);
    state_t     state, state_n;
    logic       sda_q, sda_chg, su_tc, buf_tc, scl_r;
    logic       init, init_n, iv, iv_n, mid, mid_n, fin, fin_n;
    logic [1:0] cnt, cnt_n;

    assign sda_chg = bus.i_sda != sda_q;

    i2c_passthru_ref_timer #(.LOAD(F_REF_T_SU_DAT), .WIDTH(WIDTH_F_REF_T_SU_DAT)) u_su (
        .clk(i_clk), .rst(i_rst), .f_ref(bus.i_f_ref), .load(sda_chg), .tc(su_tc)
    );
    i2c_passthru_ref_timer #(.LOAD(F_REF_T_LOW), .WIDTH(WIDTH_F_REF_T_LOW)) u_buf (
        .clk(i_clk), .rst(i_rst), .f_ref(bus.i_f_ref), .load(sda_chg || !bus.i_scl), .tc(buf_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= FREE;
            sda_q <= 1'b1;
            scl_r <= 1'b1;
            init  <= 1'b0;
            iv    <= 1'b0;
            mid   <= 1'b0;
            fin   <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            sda_q <= bus.i_sda;
            scl_r <= !(state_n inside {IDLE, SETUP});
            init  <= init_n;
            iv    <= iv_n;
            mid   <= mid_n;
            fin   <= fin_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        init_n  = init;
        iv_n    = iv;
        mid_n   = mid;
        fin_n   = fin;
        cnt_n   = cnt;
        case (state)
            FREE: if (bus.i_scl && sda_q && !bus.i_sda) begin
                state_n = HIGH;
                init_n  = 1'b1;
                iv_n    = 1'b1;
                fin_n   = 1'b0;
                mid_n   = 1'b1;
                cnt_n   = 2'd1;
            end
            IDLE: if (bus.i_start_rx) begin
                state_n = SETUP;
                mid_n   = 1'b0;
                iv_n    = 1'b0;
                cnt_n   = 2'd0;
            end
            SETUP: begin
                init_n = bus.i_sda;
                if (su_tc && !sda_chg) begin
                    iv_n    = 1'b1;
                    state_n = REL;
                end
            end
            REL: begin
                init_n = bus.i_sda;
                iv_n   = bus.i_scl || (!sda_chg && (su_tc || iv));
                if (bus.i_scl) begin
                    state_n = HIGH;
                    fin_n   = bus.i_sda;
                end
            end
            // a fall wins over a same-cycle SDA change, so final keeps its prior value
            HIGH: if (!bus.i_scl) state_n = IDLE;
            else if (sda_chg) begin
                fin_n = bus.i_sda;
                mid_n = 1'b1;
                cnt_n = cnt == 2'd3 ? cnt : cnt + 2'd1;
                if (cnt == 2'd2) state_n = VIOLATION;
            end else if (cnt != 2'd0 && fin && !init && buf_tc) state_n = FREE;
            default: ;
        endcase
    end

    assign bus.o_scl            = scl_r;
    assign bus.o_sda_init_valid = iv;
    assign bus.o_sda_init       = init;
    assign bus.o_sda_mid_change = mid;
    assign bus.o_sda_final      = fin;
    assign bus.o_done           = state inside {IDLE, FREE};
    assign bus.o_bus_free       = state == FREE;
    assign bus.o_violation      = state == VIOLATION;
endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// tb_i2c_passthru_bitrx: directed bit-period scenarios; outputs packed as
// {scl, init_valid, init, mid_change, final, done, bus_free, violation}.
module tb_i2c_passthru_bitrx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    i2c_passthru_bitrx_if bus ();
    i2c_passthru_bitrx dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_f_ref = 1'b1;
            tick();
            bus.i_f_ref = 1'b0;
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bus.o_scl, bus.o_sda_init_valid, bus.o_sda_init, bus.o_sda_mid_change,
               bus.o_sda_final, bus.o_done, bus.o_bus_free, bus.o_violation};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        bus.i_f_ref = 1'b0;
        bus.i_start_rx = 1'b0;
        bus.i_scl = 1'b1;
        bus.i_sda = 1'b1;
        tick();
        tick();
        chk("reset", 8'b1000_0110);
        rst = 1'b0;
        tick();
        chk("free_after_reset", 8'b1000_0110);
        // START then first SCL fall
        bus.i_sda = 1'b0;
        tick();
        chk("start_high", 8'b1111_0000);
        bus.i_scl = 1'b0;
        tick();
        chk("start_fall_idle", 8'b0111_0100);
        // next bit with init=1
        bus.i_start_rx = 1'b1;
        tick();
        bus.i_start_rx = 1'b0;
        chk("setup_enter", 8'b0010_0000);
        bus.i_sda = 1'b1;
        tick();
        chk("setup_sda1", 8'b0010_0000);
        pulse(1);
        chk("setup_one_ref", 8'b0010_0000);
        pulse(1);
        chk("rel_valid", 8'b1110_0000);
        // SDA wobble while released
        bus.i_sda = 1'b0;
        tick();
        chk("rel_drop0", 8'b1000_0000);
        bus.i_sda = 1'b1;
        tick();
        chk("rel_drop1", 8'b1010_0000);
        pulse(1);
        chk("rel_still_invalid", 8'b1010_0000);
        pulse(1);
        chk("rel_revalid", 8'b1110_0000);
        bus.i_scl = 1'b1;
        tick();
        chk("bit1_high", 8'b1110_1000);
        // fall with simultaneous SDA change: final keeps prior, no mid change
        bus.i_scl = 1'b0;
        bus.i_sda = 1'b0;
        tick();
        chk("bit1_fall_simul", 8'b0110_1100);
        // STOP bit
        bus.i_start_rx = 1'b1;
        tick();
        bus.i_start_rx = 1'b0;
        chk("stop_setup_enter", 8'b0010_1000);
        tick();
        chk("stop_setup_init0", 8'b0000_1000);
        pulse(2);
        chk("stop_rel", 8'b1100_1000);
        bus.i_scl = 1'b1;
        tick();
        chk("stop_high", 8'b1100_0000);
        bus.i_sda = 1'b1;
        tick();
        chk("stop_sda_rise", 8'b1101_1000);
        pulse(37);
        chk("stop_buf_37", 8'b1101_1000);
        pulse(1);
        chk("stop_free", 8'b1101_1110);
        bus.i_start_rx = 1'b1;
        tick();
        bus.i_start_rx = 1'b0;
        chk("free_ignores_start_rx", 8'b1101_1110);
        // START, then a bit with STOP+START+extra change in one high
        bus.i_sda = 1'b0;
        tick();
        chk("start2_high", 8'b1111_0000);
        bus.i_scl = 1'b0;
        tick();
        chk("start2_idle", 8'b0111_0100);
        bus.i_start_rx = 1'b1;
        tick();
        bus.i_start_rx = 1'b0;
        chk("v_setup", 8'b0010_0000);
        pulse(2);
        chk("v_rel", 8'b1100_0000);
        bus.i_scl = 1'b1;
        tick();
        chk("v_high", 8'b1100_0000);
        bus.i_sda = 1'b1;
        tick();
        chk("v_chg1", 8'b1101_1000);
        bus.i_sda = 1'b0;
        tick();
        chk("v_chg2", 8'b1101_0000);
        bus.i_sda = 1'b1;
        tick();
        chk("v_chg3", 8'b1101_1001);
        bus.i_scl = 1'b0;
        bus.i_start_rx = 1'b1;
        tick();
        bus.i_start_rx = 1'b0;
        bus.i_scl = 1'b1;
        pulse(40);
        chk("v_sticky", 8'b1101_1001);
        rst = 1'b1;
        #1;
        chk("v_async_reset", 8'b1000_0110);
        tick();
        rst = 1'b0;
        tick();
        // async reset mid-HIGH, then from IDLE (SCL released without a clock edge)
        bus.i_sda = 1'b0;
        tick();
        chk("r_high", 8'b1111_0000);
        rst = 1'b1;
        #1;
        chk("r_async_high", 8'b1000_0110);
        bus.i_sda = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.i_sda = 1'b0;
        tick();
        bus.i_scl = 1'b0;
        tick();
        chk("r_idle", 8'b0111_0100);
        rst = 1'b1;
        #1;
        chk("r_async_idle", 8'b1000_0110);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
